// File: rtl/vector_lsu.sv
// Vector load/store sequencer in front of a word-wide data memory.
// Takes one vector request, issues one element access per cycle starting at lane 0,
// gathers the load results into one packed response, and holds it until the consumer accepts it.
// Optional feature: define VLSU_STRIDE_EN to honour req_stride. Without it, the stride is fixed
// at +1 word and no stride register or multiplier is built.
module vector_lsu #(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [31:0]                 req_base,
  input  logic [15:0]                 req_stride,
  input  logic [NUM_LANES*DATA_W-1:0] req_wdata,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [NUM_LANES*DATA_W-1:0] resp_rdata,
  output logic                        mem_we,
  output logic [31:0]                 mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                      state_q, state_d;
  logic [LANE_W-1:0]           lane_q, lane_d;
  logic                        we_q, we_d;
  logic [29:0]                 base_q, base_d;  // word address; byte offset bits are dropped
  logic [NUM_LANES*DATA_W-1:0] wdata_q, wdata_d;
  logic [NUM_LANES*DATA_W-1:0] rdata_q, rdata_d;
  logic [29:0]                 lane_off;
  logic [29:0]                 word_addr;
  logic [DATA_W-1:0]           wr_elem;
  logic                        accept;
  logic                        unused_base;

  assign accept      = req_valid && (state_q == IDLE);
  assign unused_base = ^req_base[1:0];

`ifdef VLSU_STRIDE_EN
  logic signed [15:0] stride_q, stride_d;

  // Stride is captured with the rest of the request
  always_comb begin
    stride_d = stride_q;
    if (accept) stride_d = req_stride;
  end

  // Stride register carries no reset; it is only read in ACCESS
  always_ff @(posedge clk) begin
    stride_q <= stride_d;
  end

  // Word offset of this lane: lane * sext(stride), modulo 2^30 words
  always_comb begin
    lane_off = {{14{stride_q[15]}}, stride_q} * {{(30 - LANE_W){1'b0}}, lane_q};
  end
`else
  logic unused_stride;
  assign unused_stride = ^req_stride;

  // Unit stride: the word offset is the lane index itself
  always_comb begin
    lane_off = {{(30 - LANE_W){1'b0}}, lane_q};
  end
`endif

  assign word_addr = base_q + lane_off;

  // Pick the store element belonging to the current lane
  always_comb begin
    wr_elem = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_q == LANE_W'(i)) wr_elem = wdata_q[DATA_W*i +: DATA_W];
    end
  end

  // Request capture, lane counting and load gathering
  always_comb begin
    we_d    = we_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    lane_d  = lane_q;
    if (accept) begin
      we_d    = req_we;
      base_d  = req_base[31:2];
      wdata_d = req_wdata;
      rdata_d = '0;
      lane_d  = '0;
    end else if (state_q == ACCESS) begin
      lane_d = lane_q + LANE_W'(1);
      if (!we_q) begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (lane_q == LANE_W'(i)) rdata_d[DATA_W*i +: DATA_W] = mem_rdata;
        end
      end
    end
  end

  // Next-state logic: IDLE -> ACCESS (NUM_LANES cycles) -> RESP -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid)            state_d = ACCESS;
      ACCESS:  if (lane_q == LAST_LANE)  state_d = RESP;
      RESP:    if (resp_ready)           state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  // State, lane counter and response register; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lane_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      rdata_q <= rdata_d;
    end
  end

  // Latched request fields; only consumed while an operation is in flight
  always_ff @(posedge clk) begin
    we_q    <= we_d;
    base_q  <= base_d;
    wdata_q <= wdata_d;
  end

  // Outputs: memory port is active only in ACCESS, handshakes follow the state
  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    resp_rdata = rdata_q;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (state_q == ACCESS) begin
      mem_we   = we_q;
      mem_addr = {word_addr, 2'b00};
      if (we_q) mem_wdata = wr_elem;
    end
  end

endmodule

// File: tb/tb_vector_lsu.sv
// Directed bench for vector_lsu with a small word memory model behind the memory port.
module tb_vector_lsu;

`ifdef VLSU_STRIDE_EN
  localparam bit STRIDE_EN = 1'b1;
`else
  localparam bit STRIDE_EN = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic         req_we;
  logic [31:0]  req_base;
  logic [15:0]  req_stride;
  logic [127:0] req_wdata;
  logic         resp_valid;
  logic         resp_ready;
  logic [127:0] resp_rdata;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [31:0]  mem_rdata;
  logic         mem_clr;
  logic [31:0]  mem [256];

  int n_checks = 0;
  int n_errors = 0;

  vector_lsu #(.NUM_LANES(4), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_base   (req_base),
    .req_stride (req_stride),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, registered write, 256 words aliased on addr[9:2]
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Present a request at the current negedge; returns at the negedge of lane 0
  task automatic issue(input logic we, input logic [31:0] base, input logic [15:0] stride,
                       input logic [127:0] wdata);
    check("req_ready_idle", req_ready, 1);
    req_valid  = 1'b1;
    req_we     = we;
    req_base   = base;
    req_stride = stride;
    req_wdata  = wdata;
    @(negedge clk);
    req_valid  = 1'b0;
  endtask

  // Check four lane cycles; returns at the first RESP negedge
  task automatic lanes(input logic we, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] a2, input logic [31:0] a3, input logic [127:0] wdata);
    logic [31:0] ea [4];
    ea = '{a0, a1, a2, a3};
    for (int i = 0; i < 4; i++) begin
      check($sformatf("lane%0d_addr", i), mem_addr, ea[i]);
      check($sformatf("lane%0d_we", i), mem_we, we);
      if (we) check($sformatf("lane%0d_wdata", i), mem_wdata, wdata[32*i +: 32]);
      check($sformatf("lane%0d_resp_valid_low", i), resp_valid, 0);
      check($sformatf("lane%0d_req_ready_low", i), req_ready, 0);
      @(negedge clk);
    end
  endtask

  task automatic take_resp(input logic [127:0] exp_rdata);
    check("resp_valid", resp_valid, 1);
    check("resp_rdata", resp_rdata, exp_rdata);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_valid_drop", resp_valid, 0);
    check("req_ready_back", req_ready, 1);
    check("idle_mem_we", mem_we, 0);
    check("idle_mem_addr", mem_addr, 0);
  endtask

  task automatic op(input logic we, input logic [31:0] base, input logic [15:0] stride,
                    input logic [127:0] wdata, input logic [31:0] a0, input logic [31:0] a1,
                    input logic [31:0] a2, input logic [31:0] a3, input logic [127:0] exp_rdata);
    issue(we, base, stride, wdata);
    lanes(we, a0, a1, a2, a3, wdata);
    take_resp(exp_rdata);
  endtask

  initial begin
    logic [127:0] v_ld;
    logic [127:0] v_st2;
    logic [127:0] v_wrap;
    logic [127:0] v_rst;
    clk        = 1'b0;
    reset      = 1'b1;
    mem_clr    = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_base   = '0;
    req_stride = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    v_ld   = {32'd44, 32'd33, 32'd22, 32'd11};
    v_st2  = {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};
    v_wrap = {32'h5A5A0003, 32'h5A5A0002, 32'h5A5A0001, 32'h5A5A0000};
    v_rst  = {32'h0E0E0003, 32'h0E0E0002, 32'h0E0E0001, 32'h0E0E0000};
    repeat (3) @(negedge clk);
    reset   = 1'b0;
    mem_clr = 1'b0;

    // Reset values
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);

    // Unit-stride store of 11,22,33,44 at 0x100, then load it back
    op(1'b1, 32'h100, 16'd1, v_ld, 32'h100, 32'h104, 32'h108, 32'h10C, 128'd0);
    op(1'b0, 32'h100, 16'd1, 128'd0, 32'h100, 32'h104, 32'h108, 32'h10C, v_ld);

    // Unaligned base ignores the low two address bits
    op(1'b0, 32'h103, 16'd1, 128'd0, 32'h100, 32'h104, 32'h108, 32'h10C, v_ld);

    // Stride-2 store and readback
    op(1'b1, 32'h200, 16'd2, v_st2, 32'h200, STRIDE_EN ? 32'h208 : 32'h204,
       STRIDE_EN ? 32'h210 : 32'h208, STRIDE_EN ? 32'h218 : 32'h20C, 128'd0);
    op(1'b0, 32'h200, 16'd2, 128'd0, 32'h200, STRIDE_EN ? 32'h208 : 32'h204,
       STRIDE_EN ? 32'h210 : 32'h208, STRIDE_EN ? 32'h218 : 32'h20C, v_st2);

    // Store across the top of the address space, then a negative-stride load through zero
    op(1'b1, 32'hFFFFFFF8, 16'd1, v_wrap, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'h0, 32'h4, 128'd0);
    op(1'b0, 32'h4, 16'hFFFF, 128'd0, 32'h4,
       STRIDE_EN ? 32'h0 : 32'h8, STRIDE_EN ? 32'hFFFFFFFC : 32'hC,
       STRIDE_EN ? 32'hFFFFFFF8 : 32'h10,
       STRIDE_EN ? {32'h5A5A0000, 32'h5A5A0001, 32'h5A5A0002, 32'h5A5A0003}
                 : {32'h0, 32'h0, 32'h0, 32'h5A5A0003});

    // Back-pressure: response held while a second request waits
    issue(1'b0, 32'h100, 16'd1, 128'd0);
    lanes(1'b0, 32'h100, 32'h104, 32'h108, 32'h10C, 128'd0);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_base   = 32'h200;
    req_stride = 16'd1;
    for (int i = 0; i < 3; i++) begin
      check("bp_resp_valid", resp_valid, 1);
      check("bp_resp_rdata", resp_rdata, v_ld);
      check("bp_req_ready", req_ready, 0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("bp_after_hs_resp_valid", resp_valid, 0);
    check("bp_after_hs_req_ready", req_ready, 1);
    check("bp_after_hs_mem_addr", mem_addr, 0);
    @(negedge clk);
    req_valid = 1'b0;
    lanes(1'b0, 32'h200, 32'h204, 32'h208, 32'h20C, 128'd0);
    take_resp(STRIDE_EN ? {32'h0, 32'hBBBB0002, 32'h0, 32'hAAAA0001} : v_st2);

    // Reset in the lane-1 cycle of a store
    issue(1'b1, 32'h40, 16'd1, v_rst);
    check("rst_op_lane0_addr", mem_addr, 32'h40);
    @(negedge clk);
    check("rst_op_lane1_addr", mem_addr, 32'h44);
    check("rst_op_lane1_we", mem_we, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_req_ready", req_ready, 1);
    check("abort_resp_valid", resp_valid, 0);
    check("abort_resp_rdata", resp_rdata, 0);
    check("abort_mem_we", mem_we, 0);
    check("abort_mem_addr", mem_addr, 0);
    check("abort_mem_wdata", mem_wdata, 0);
    for (int i = 0; i < 4; i++) begin
      check("abort_no_resp", resp_valid, 0);
      check("abort_no_we", mem_we, 0);
      @(negedge clk);
    end
    op(1'b0, 32'h40, 16'd1, 128'd0, 32'h40, 32'h44, 32'h48, 32'h4C,
       {32'h0, 32'h0, 32'h0E0E0001, 32'h0E0E0000});

    // Stride 0 store then load
    op(1'b1, 32'h300, 16'd0, {32'd4, 32'd3, 32'd2, 32'd1}, 32'h300,
       STRIDE_EN ? 32'h300 : 32'h304, STRIDE_EN ? 32'h300 : 32'h308,
       STRIDE_EN ? 32'h300 : 32'h30C, 128'd0);
    op(1'b0, 32'h300, 16'd0, 128'd0, 32'h300,
       STRIDE_EN ? 32'h300 : 32'h304, STRIDE_EN ? 32'h300 : 32'h308,
       STRIDE_EN ? 32'h300 : 32'h30C,
       STRIDE_EN ? {32'd4, 32'd4, 32'd4, 32'd4} : {32'd4, 32'd3, 32'd2, 32'd1});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
